// File: rtl/autoscale_pkg.sv
// Shared types and helpers for the multi-lane autoscaler: mode encoding,
// MSB search and shift clamping used by the frame-end shift control.
package autoscale_pkg;

  typedef enum logic {
    AUTO   = 1'b0,
    MANUAL = 1'b1
  } mode_e;

  // Widest peak word the MSB search handles; narrower words are zero-extended.
  localparam int MSB_W = 64;

  function automatic int msb_index(input logic [MSB_W-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < MSB_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int clamp_shift(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/autoscale_multi_if.sv
// Streaming sample bus of the autoscaler: packed input lanes with control,
// packed scaled output lanes with saturation flags and shift status.
interface autoscale_multi_if #(
  parameter int N_CHANNELS  = 2,
  parameter int DIN_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 18,
  parameter int SHIFT_WIDTH = 6
);

  logic [N_CHANNELS*DIN_WIDTH-1:0]  din;
  logic                             din_valid;
  logic                             sync_in;
  logic                             mode;
  logic [SHIFT_WIDTH-1:0]           manual_shift;
  logic [N_CHANNELS*DOUT_WIDTH-1:0] dout;
  logic                             dout_valid;
  logic [N_CHANNELS-1:0]            sat;
  logic [SHIFT_WIDTH-1:0]           shift_value;
  logic                             shift_update;

  modport master (
    output din, din_valid, sync_in, mode, manual_shift,
    input  dout, dout_valid, sat, shift_value, shift_update
  );

  modport slave (
    input  din, din_valid, sync_in, mode, manual_shift,
    output dout, dout_valid, sat, shift_value, shift_update
  );

endinterface

// File: rtl/autoscale_lane.sv
// Output stage for one lane: right-shift by the shift captured with the
// sample, then saturate to the narrower output width.
module autoscale_lane #(
  parameter int DIN_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 18,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [DIN_WIDTH-1:0]   i_din,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [DOUT_WIDTH-1:0]  o_dout,
  output logic                   o_sat
);

  logic [DIN_WIDTH-1:0] w_y;

  assign w_y = i_din >> i_shift;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dout <= '0;
      o_sat  <= 1'b0;
    end else if (i_valid) begin
      if (|w_y[DIN_WIDTH-1:DOUT_WIDTH]) begin
        o_dout <= '1;
        o_sat  <= 1'b1;
      end else begin
        o_dout <= w_y[DOUT_WIDTH-1:0];
        o_sat  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/autoscale_multi.sv
// Multi-lane autoscaler: tracks the per-frame peak across all lanes, updates a
// common right-shift at each frame end and scales every lane through 2 stages.
module autoscale_multi
  import autoscale_pkg::*;
#(
  parameter int N_CHANNELS  = 2,
  parameter int DIN_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 18,
  parameter int MIN_SHIFT   = 4,
  parameter int MAX_SHIFT   = 14,
  parameter int FRAME_LEN   = 2048,
  parameter int SHIFT_WIDTH = 6
) (
  input logic             clk,
  input logic             rst,
  autoscale_multi_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  logic [CNT_W-1:0]                r_cnt;
  logic [DIN_WIDTH-1:0]            r_peak;
  logic [SHIFT_WIDTH-1:0]          r_shift;
  logic                            r_shift_update;
  logic [N_CHANNELS*DIN_WIDTH-1:0] r_s1_din;
  logic                            r_s1_valid;
  logic [SHIFT_WIDTH-1:0]          r_s1_shift;
  logic                            r_s2_valid;

  logic [DIN_WIDTH-1:0]                   w_lanes_or;
  logic                                   w_frame_end;
  int                                     w_msb;
  int                                     w_target;
  logic [SHIFT_WIDTH-1:0]                 w_next_shift;
  logic [N_CHANNELS-1:0][DOUT_WIDTH-1:0]  w_dout;
  logic [N_CHANNELS-1:0]                  w_sat;

  // NOTE: every combinational output gets a default before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_lanes_or = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      w_lanes_or = w_lanes_or | bus.din[k*DIN_WIDTH +: DIN_WIDTH];
    end
  end

  assign w_frame_end = bus.din_valid && !bus.sync_in &&
                       (r_cnt == CNT_W'(FRAME_LEN - 1));

  // Attack is immediate, decay is one step per frame; manual ignores both.
  always_comb begin
    w_msb    = msb_index(MSB_W'(r_peak | w_lanes_or));
    w_target = clamp_shift(w_msb + 1 - DOUT_WIDTH, MIN_SHIFT, MAX_SHIFT);
    if (mode_e'(bus.mode) == MANUAL) begin
      w_next_shift = SHIFT_WIDTH'(clamp_shift(int'(bus.manual_shift), MIN_SHIFT, MAX_SHIFT));
    end else if (w_target >= int'(r_shift)) begin
      w_next_shift = SHIFT_WIDTH'(w_target);
    end else begin
      w_next_shift = r_shift - SHIFT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_peak         <= '0;
      r_shift        <= SHIFT_WIDTH'(MAX_SHIFT);
      r_shift_update <= 1'b0;
    end else begin
      r_shift_update <= w_frame_end;
      if (bus.sync_in) begin
        r_peak <= '0;
        r_cnt  <= bus.din_valid ? CNT_W'(1) : '0;
      end else if (bus.din_valid) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_frame_end) begin
          r_peak  <= '0;
          r_shift <= w_next_shift;
        end else begin
          r_peak <= r_peak | w_lanes_or;
        end
      end
    end
  end

  // Stage 1 captures the shift in force at acceptance, so the frame-end
  // sample is still scaled with the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_din   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_shift <= SHIFT_WIDTH'(MAX_SHIFT);
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_din   <= bus.din;
      r_s1_valid <= bus.din_valid;
      r_s1_shift <= r_shift;
      r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_lane
    autoscale_lane #(
      .DIN_WIDTH   (DIN_WIDTH),
      .DOUT_WIDTH  (DOUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_s1_valid),
      .i_din   (r_s1_din[k*DIN_WIDTH +: DIN_WIDTH]),
      .i_shift (r_s1_shift),
      .o_dout  (w_dout[k]),
      .o_sat   (w_sat[k])
    );
  end

  assign bus.dout         = w_dout;
  assign bus.sat          = w_sat;
  assign bus.dout_valid   = r_s2_valid;
  assign bus.shift_value  = r_shift;
  assign bus.shift_update = r_shift_update;

endmodule

// File: doc/autoscale_multi.md
# autoscale_multi

Parametrised multi-channel autoscaler for the FRB detection datapath, sitting between the accumulated-power spectrometer output and the narrower detection/dedispersion stages. It tracks the peak of all channels over each frame (one spectrum), and at the frame boundary derives a common right-shift. The shift is clamped to [MIN_SHIFT, MAX_SHIFT], rises immediately and decays by at most one step per frame. Every sample is shifted and saturated to DOUT_WIDTH. A manual mode overrides the computed shift.

## Interface
- N_CHANNELS, 2, number of parallel unsigned data lanes sharing one shift
- DIN_WIDTH, 32, input sample width (unsigned)
- DOUT_WIDTH, 18, output sample width (unsigned)
- MIN_SHIFT, 4, lower clamp of the applied shift
- MAX_SHIFT, 14, upper clamp and reset value of the applied shift
- FRAME_LEN, 2048, valid samples per frame; a power of two ≥2
- SHIFT_WIDTH, 6, width of the shift ports
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- din  in  N_CHANNELS*DIN_WIDTH  packed samples; lane k at [k*DIN_WIDTH +: DIN_WIDTH]
- din_valid  in  1  qualifies din
- sync_in  in  1  frame restart; the current sample (if valid) becomes frame index 0
- mode  in  1  0 = auto, 1 = manual
- manual_shift  in  SHIFT_WIDTH  requested shift in manual mode
- dout  out  N_CHANNELS*DOUT_WIDTH  packed scaled samples, same lane packing
- dout_valid  out  1  qualifies dout and sat
- sat  out  N_CHANNELS  per-lane saturation flag for the current dout
- shift_value  out  SHIFT_WIDTH  shift currently in force for newly accepted samples
- shift_update  out  1  one-cycle pulse when shift_value is reloaded at a frame end

## Operation
- Frame counter counts accepted samples (din_valid=1), 0..FRAME_LEN-1, and wraps.
- peak_or accumulates the bitwise OR of all lanes of every accepted sample in the frame.
- Frame end: an accepted sample at index FRAME_LEN-1 with sync_in=0. At frame end:
  - f = peak_or | OR of the current lanes.
  - p = index of the MSB of f, or -1 if f = 0.
  - target = clamp(p+1-DOUT_WIDTH, MIN_SHIFT, MAX_SHIFT), computed with signed arithmetic.
- Auto mode update of shift_value:
  - if target ≥ shift_value: load target (attack is immediate);
  - otherwise: load shift_value-1 (decay is one step per frame).
- Manual mode: at frame end, load clamp(manual_shift, MIN_SHIFT, MAX_SHIFT). No decay limit.
- Every frame end: shift_update=1 and peak_or cleared. shift_update pulses even when the value is unchanged.
- mode and manual_shift are sampled only at frame end. Changing them mid-frame has no effect before the boundary.
- sync_in=1 (regardless of din_valid):
  - partial frame discarded: no shift update, no pulse;
  - peak_or cleared;
  - counter set so that the current sample, if valid, is index 0 (counter=1 after it), else counter=0.
  - A sync_in coinciding with index FRAME_LEN-1 takes priority over the frame end.
- Per-lane datapath:
  - y = din_k >> s, where s is shift_value at acceptance;
  - if y ≥ 2^DOUT_WIDTH: dout_k = all ones, sat_k=1;
  - else dout_k = y[DOUT_WIDTH-1:0], sat_k=0.
- The frame-end sample itself is scaled with the old shift. The next accepted sample uses the new shift.

## Timing
- Two-stage pipeline, latency 2 cycles from din_valid to dout_valid.
  - Stage 1 registers din, din_valid and shift_value.
  - Stage 2 registers the shift/saturate result, sat and dout_valid.
- No backpressure. A valid sample is accepted every cycle; gaps in din_valid propagate unchanged.
- shift_value and shift_update change on the clock edge that accepts the frame-end sample. shift_update is high for exactly that following cycle.
- Reset values:
  - shift_value = MAX_SHIFT;
  - dout = 0, sat = 0, dout_valid = 0, shift_update = 0;
  - counter = 0, peak_or = 0, pipeline valids = 0.
- Reset mid-frame drops in-flight pipeline samples. The first frame after reset starts at the first accepted sample.

## Structure
- Package autoscale_pkg:
  - mode encodings AUTO/MANUAL;
  - function msb_index (returns signed, -1 for zero);
  - function clamp_shift.
- Sub-module autoscale_lane, one per lane via generate: stage-2 shift and saturate for one lane, with parameters DIN_WIDTH, DOUT_WIDTH, SHIFT_WIDTH.
- The top holds the frame counter, peak_or, shift control and stage-1 registers.

## Test plan
Bench parameters: N_CHANNELS=2, DIN=32, DOUT=18, MIN=4, MAX=14, FRAME_LEN=8.
- Reset: assert rst mid-stream -> shift_value=14, dout=0, dout_valid=0, shift_update=0 immediately (asynchronous).
- Decay: frames with peak 0x0010_0000 (p=20, target 4) -> shift_value steps 14,13,…,4 over 10 frames and then holds at 4. One shift_update per frame.
- Attack: at shift 4, a single sample 0xFFFF_FFFF in lane 1 -> target 14, shift_value=14 after that frame. That frame's own samples are still scaled by 4.
- Saturation: shift 4, lane 0 = 0x0040_0000 -> dout lane0 = 0x3FFFF, sat=2'b01. Lane 1 = 0x0003_FFF0 -> 0x3FFF, sat bit 0. Both appear 2 cycles after input.
- Manual: mode=1, manual_shift=20 mid-frame -> no change until frame end, then shift_value=14. With manual_shift=0 -> 4 at the next end.
- Sync: sync_in with valid at index 5 -> no shift_update. The next frame end occurs 8 accepted samples later, using only that frame's peak.
